// File: rtl/matrix_cps_pkg.sv
// matrix_cps_pkg
//   Shared types for the matrix LSU issue path. The issued instruction and
//   its CSR configuration travel together from a requester to the shared
//   register loader/storer.
package matrix_cps_pkg;

  // Instruction word handed to the shared loader/storer.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] md;
    logic [7:0] rs1;
  } lsu_instr_t;

  // CSR configuration sampled together with the instruction.
  typedef struct packed {
    logic [15:0] stride;
    logic [7:0]  rows;
  } lsu_conf_t;

endpackage

// File: rtl/matrix_lsu_arbiter.sv
// matrix_lsu_arbiter
//   Arbitrates N_REQ LSU issue sources onto one shared loader/storer.
//   One instruction + configuration is accepted per grant (valid/ready),
//   the shared unit gets a one-cycle start pulse, and no further grant is
//   given until the unit reports idle again.
//
//   Selection: round-robin by default. Defining the macro
//   MATRIX_LSU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
//   and removes the round-robin pointer.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   req_valid_i  per-requester instruction pending
//   req_instr_i  per-requester instruction
//   req_conf_i   per-requester configuration
//   req_ready_o  one-hot grant (transfer = valid & ready)
//   lsu_busy_i   shared unit busy
//   lsu_start_o  one-cycle start pulse to the shared unit
//   lsu_instr_o  registered issued instruction
//   lsu_conf_o   registered issued configuration
//   grant_id_o   owner of the current/last operation
//   done_o       one-cycle pulse when the owned operation completes
module matrix_lsu_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  matrix_cps_pkg::lsu_instr_t req_instr_i [N_REQ],
  input  matrix_cps_pkg::lsu_conf_t  req_conf_i  [N_REQ],
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic                       lsu_busy_i,
  output logic                       lsu_start_o,
  output matrix_cps_pkg::lsu_instr_t lsu_instr_o,
  output matrix_cps_pkg::lsu_conf_t  lsu_conf_o,
  output logic [ID_W-1:0]            grant_id_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]            winner;
  logic                       any_valid;
  logic                       grant_en;
  logic [N_REQ-1:0]           grant_vec;

  matrix_cps_pkg::lsu_instr_t instr_reg;
  matrix_cps_pkg::lsu_conf_t  conf_reg;
  logic [ID_W-1:0]            grant_id_reg;

  // ---------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------
`ifdef MATRIX_LSU_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest valid index is the last write.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        winner    = ID_W'(i);
        any_valid = 1'b1;
      end
    end
  end
`else
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] last_ptr_reg, last_ptr_next;

  // Walk last_ptr+1, last_ptr+2, ... with an explicit wrap at N_REQ-1 so
  // that for non-power-of-two N_REQ no out-of-range index is ever visited.
  // The final step returns to last_ptr itself, so a lone requester that
  // just won can win again.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = last_ptr_reg;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + ID_W'(1);
      if (!any_valid && req_valid_i[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

  // Pointer moves only on an actual transfer.
  always_comb begin
    last_ptr_next = last_ptr_reg;
    if (grant_en) begin
      last_ptr_next = winner;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_ptr_reg <= LAST_IDX;
    end else begin
      last_ptr_reg <= last_ptr_next;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------
  // Busy is honoured in IDLE too: after a reset the shared unit may still
  // be finishing a stale operation, and we must not overlap it.
  assign grant_en = (state_reg == IDLE) && !lsu_busy_i && any_valid;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant_vec[gi] = (winner == ID_W'(gi));
    end
  endgenerate

  assign req_ready_o = grant_en ? grant_vec : '0;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    lsu_start_o = 1'b0;
    done_o      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (grant_en) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Busy deliberately ignored: the unit may raise it a cycle late.
        lsu_start_o = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        if (!lsu_busy_i) begin
          done_o     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Issued data, held until the next transfer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_reg    <= '0;
      conf_reg     <= '0;
      grant_id_reg <= '0;
    end else if (grant_en) begin
      instr_reg    <= req_instr_i[winner];
      conf_reg     <= req_conf_i[winner];
      grant_id_reg <= winner;
    end
  end

  assign lsu_instr_o = instr_reg;
  assign lsu_conf_o  = conf_reg;
  assign grant_id_o  = grant_id_reg;

endmodule

// File: tb/tb_matrix_lsu_arbiter.sv
module tb_matrix_lsu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- N_REQ = 2 instance ----------------
  logic [1:0]                 valid2;
  matrix_cps_pkg::lsu_instr_t instr2 [2];
  matrix_cps_pkg::lsu_conf_t  conf2  [2];
  logic [1:0]                 ready2;
  logic                       busy2;
  logic                       start2;
  matrix_cps_pkg::lsu_instr_t instr_o2;
  matrix_cps_pkg::lsu_conf_t  conf_o2;
  logic [0:0]                 gid2;
  logic                       done2;

  matrix_lsu_arbiter #(.N_REQ(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid2), .req_instr_i(instr2), .req_conf_i(conf2),
    .req_ready_o(ready2), .lsu_busy_i(busy2), .lsu_start_o(start2),
    .lsu_instr_o(instr_o2), .lsu_conf_o(conf_o2),
    .grant_id_o(gid2), .done_o(done2)
  );

  // ---------------- N_REQ = 3 instance ----------------
  logic [2:0]                 valid3;
  matrix_cps_pkg::lsu_instr_t instr3 [3];
  matrix_cps_pkg::lsu_conf_t  conf3  [3];
  logic [2:0]                 ready3;
  logic                       busy3;
  logic                       start3;
  matrix_cps_pkg::lsu_instr_t instr_o3;
  matrix_cps_pkg::lsu_conf_t  conf_o3;
  logic [1:0]                 gid3;
  logic                       done3;

  matrix_lsu_arbiter #(.N_REQ(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid3), .req_instr_i(instr3), .req_conf_i(conf3),
    .req_ready_o(ready3), .lsu_busy_i(busy3), .lsu_start_o(start3),
    .lsu_instr_o(instr_o3), .lsu_conf_o(conf_o3),
    .grant_id_o(gid3), .done_o(done3)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic        busy;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [1:0]  ready;
    logic        start;
    logic        done;
    logic        gid;
    logic [15:0] instr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [1:0] v, input logic b,
                     input logic [15:0] i0, input logic [15:0] i1,
                     input logic [1:0] rdy, input logic st, input logic dn,
                     input logic g, input logic [15:0] ins);
    vec_t e;
    e.rst = r; e.valid = v; e.busy = b; e.in0 = i0; e.in1 = i1;
    e.ready = rdy; e.start = st; e.done = dn; e.gid = g; e.instr = ins;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp_r3;
    logic [1:0]  exp_g3 [3];
    logic [23:0] exp_conf;

    valid2 = '0; busy2 = 1'b0;
    instr2[0] = '0; instr2[1] = '0; conf2[0] = '0; conf2[1] = '0;
    valid3 = '0; busy3 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      instr3[r] = matrix_cps_pkg::lsu_instr_t'(16'hC000 | 16'(r));
      conf3[r]  = matrix_cps_pkg::lsu_conf_t'({16'hC000 | 16'(r), 8'(r)});
    end

    //   rst v  b  in0      in1      rdy st dn g  instr
    // reset state and idle
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
    // single request, busy for 4 cycles: done at T+6
    add(0, 1, 0, 16'hA001, 16'h0000, 1, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 16'hA001, 16'h0000, 0, 1, 0, 0, 16'hA001);
    add(0, 0, 1, 16'hA001, 16'h0000, 0, 0, 0, 0, 16'hA001);
    add(0, 0, 1, 16'hA001, 16'h0000, 0, 0, 0, 0, 16'hA001);
    add(0, 0, 1, 16'hA001, 16'h0000, 0, 0, 0, 0, 16'hA001);
    add(0, 0, 1, 16'hA001, 16'h0000, 0, 0, 0, 0, 16'hA001);
    add(0, 0, 0, 16'hA001, 16'h0000, 0, 0, 1, 0, 16'hA001);
    add(0, 0, 0, 16'hA001, 16'h0000, 0, 0, 0, 0, 16'hA001);
    // requester 1 alone, then reset during RUN
    add(0, 2, 0, 16'hA001, 16'hB001, 2, 0, 0, 0, 16'hA001);
    add(0, 0, 0, 16'hA001, 16'hB001, 0, 1, 0, 1, 16'hB001);
    add(0, 0, 1, 16'hA001, 16'hB001, 0, 0, 0, 1, 16'hB001);
    add(1, 0, 1, 16'hA001, 16'hB001, 0, 0, 0, 0, 16'h0000);
    // busy held across reset release: no grant until busy falls
    add(0, 3, 1, 16'hA002, 16'hB002, 0, 0, 0, 0, 16'h0000);
    add(0, 3, 1, 16'hA002, 16'hB002, 0, 0, 0, 0, 16'h0000);
    add(0, 3, 0, 16'hA002, 16'hB002, 1, 0, 0, 0, 16'h0000);
    // busy in ISSUE is ignored; zero-length op completes in first RUN cycle
    add(0, 3, 1, 16'hA003, 16'hB002, 0, 1, 0, 0, 16'hA002);
    add(0, 3, 0, 16'hA003, 16'hB002, 0, 0, 1, 0, 16'hA002);
`ifdef MATRIX_LSU_ARB_FIXED_PRIO_EN
    add(0, 3, 0, 16'hA003, 16'hB002, 1, 0, 0, 0, 16'hA002);
    add(0, 3, 0, 16'hA004, 16'hB002, 0, 1, 0, 0, 16'hA003);
    add(0, 3, 0, 16'hA004, 16'hB002, 0, 0, 1, 0, 16'hA003);
    add(0, 3, 0, 16'hA004, 16'hB002, 1, 0, 0, 0, 16'hA003);
    add(0, 3, 0, 16'hA005, 16'hB002, 0, 1, 0, 0, 16'hA004);
    add(0, 3, 0, 16'hA005, 16'hB002, 0, 0, 1, 0, 16'hA004);
    add(0, 3, 0, 16'hA005, 16'hB002, 1, 0, 0, 0, 16'hA004);
    add(0, 0, 0, 16'hA005, 16'hB002, 0, 1, 0, 0, 16'hA005);
    add(0, 0, 0, 16'hA005, 16'hB002, 0, 0, 1, 0, 16'hA005);
    add(0, 0, 0, 16'hA005, 16'hB002, 0, 0, 0, 0, 16'hA005);
`else
    // contention: alternate 0,1,0,1 every 3 cycles
    add(0, 3, 0, 16'hA003, 16'hB002, 2, 0, 0, 0, 16'hA002);
    add(0, 3, 0, 16'hA003, 16'hB003, 0, 1, 0, 1, 16'hB002);
    add(0, 3, 0, 16'hA003, 16'hB003, 0, 0, 1, 1, 16'hB002);
    add(0, 3, 0, 16'hA003, 16'hB003, 1, 0, 0, 1, 16'hB002);
    add(0, 3, 0, 16'hA004, 16'hB003, 0, 1, 0, 0, 16'hA003);
    add(0, 3, 0, 16'hA004, 16'hB003, 0, 0, 1, 0, 16'hA003);
    add(0, 3, 0, 16'hA004, 16'hB003, 2, 0, 0, 0, 16'hA003);
    add(0, 0, 0, 16'hA004, 16'hB003, 0, 1, 0, 1, 16'hB003);
    add(0, 0, 0, 16'hA004, 16'hB003, 0, 0, 1, 1, 16'hB003);
    add(0, 0, 0, 16'hA004, 16'hB003, 0, 0, 0, 1, 16'hB003);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst       = vecs[i].rst;
      valid2    = vecs[i].valid;
      busy2     = vecs[i].busy;
      instr2[0] = matrix_cps_pkg::lsu_instr_t'(vecs[i].in0);
      instr2[1] = matrix_cps_pkg::lsu_instr_t'(vecs[i].in1);
      conf2[0]  = matrix_cps_pkg::lsu_conf_t'({vecs[i].in0, 8'd0});
      conf2[1]  = matrix_cps_pkg::lsu_conf_t'({vecs[i].in1, 8'd1});
      @(negedge clk);
      exp_conf = {vecs[i].instr, 7'd0, vecs[i].gid};
      chk("ready", i, 32'(ready2), 32'(vecs[i].ready));
      chk("start", i, 32'(start2), 32'(vecs[i].start));
      chk("done",  i, 32'(done2),  32'(vecs[i].done));
      chk("gid",   i, 32'(gid2),   32'(vecs[i].gid));
      chk("instr", i, 32'(instr_o2), 32'(vecs[i].instr));
      chk("conf",  i, 32'(conf_o2),  32'(exp_conf));
    end

    // N_REQ=3: requesters 1 and 2 valid, pointer at its reset value 2
`ifdef MATRIX_LSU_ARB_FIXED_PRIO_EN
    exp_g3[0] = 2'd1; exp_g3[1] = 2'd1; exp_g3[2] = 2'd1;
`else
    exp_g3[0] = 2'd1; exp_g3[1] = 2'd2; exp_g3[2] = 2'd1;
`endif
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      valid3 = (k < 8) ? 3'b110 : 3'b000;
      @(negedge clk);
      exp_r3 = exp_g3[k / 3];
      if (k % 3 == 0) begin
        chk("n3_ready", 100 + k, 32'(ready3), 32'(3'b001 << exp_r3));
      end else begin
        chk("n3_ready", 100 + k, 32'(ready3), 32'd0);
      end
      if (k % 3 == 1) begin
        chk("n3_start", 100 + k, 32'(start3), 32'd1);
        chk("n3_gid",   100 + k, 32'(gid3),   32'(exp_r3));
        chk("n3_instr", 100 + k, 32'(instr_o3), 32'h0000C000 | 32'(exp_r3));
        chk("n3_conf",  100 + k, 32'(conf_o3),
            32'({16'hC000 | 16'(exp_r3), 8'(exp_r3)}));
      end
      if (k % 3 == 2) begin
        chk("n3_done", 100 + k, 32'(done3), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
